// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg : shared types and helpers for the sipo deserializer and its bench
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sipo_pkg;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Bit-counter width: max(1, clog2(width)).
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage : sipo_pkg

`default_nettype wire

// File: rtl/sipo_if.sv
// ---------------------------------------------------------------------------
// sipo_if : serial input, realign and valid/ready output bundle of sipo
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sipo_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic             clear;
  logic             shift_en;
  logic             serial_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] bit_count;
  logic             overflow;

  modport master (
    output clear,
    output shift_en,
    output serial_in,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  bit_count,
    input  overflow
  );

  modport slave (
    input  clear,
    input  shift_en,
    input  serial_in,
    input  out_ready,
    output out_data,
    output out_valid,
    output bit_count,
    output overflow
  );

endinterface : sipo_if

`default_nettype wire

// File: rtl/sipo_out_slot.sv
// ---------------------------------------------------------------------------
// sipo_out_slot : one-entry valid/ready holding register with drop indication
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_out_slot
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_data,
  input  wire logic             i_out_ready,
  output logic      [WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  output logic                  o_drop
);

  slot_state_t      r_state;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_load) begin
            r_state <= SLOT_FULL;
            r_data  <= i_load_data;
          end
        end
        SLOT_FULL: begin
          // A drain and a new word in the same cycle swap the contents with no bubble.
          if (i_out_ready) begin
            if (i_load) begin
              r_data <= i_load_data;
            end else begin
              r_state <= SLOT_EMPTY;
            end
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = (r_state == SLOT_FULL);
  assign o_drop      = i_load && (r_state == SLOT_FULL) && !i_out_ready;

endmodule : sipo_out_slot

`default_nettype wire

// File: rtl/sipo.sv
// ---------------------------------------------------------------------------
// sipo : MSB-first serial-in parallel-out deserializer with sticky overrun flag
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input wire logic clk,
  input wire logic rst_n,
  sipo_if.slave    bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-2:0] r_sr;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_word;
  logic             w_shift;
  logic             w_complete;
  logic             w_drop;

  // The incoming bit joins the partial word; its low WIDTH-1 bits are the next partial word.
  assign w_word     = {r_sr, bus.serial_in};
  assign w_shift    = bus.shift_en && !bus.clear;
  assign w_complete = w_shift && (r_bit_count == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_bit_count <= '0;
      r_overflow  <= 1'b0;
    end else if (bus.clear) begin
      r_sr        <= '0;
      r_bit_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_shift) begin
        r_sr        <= w_word[WIDTH-2:0];
        r_bit_count <= w_complete ? '0 : r_bit_count + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sipo_out_slot #(
    .WIDTH (WIDTH)
  ) u_out_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_complete),
    .i_load_data (w_word),
    .i_out_ready (bus.out_ready),
    .o_out_data  (bus.out_data),
    .o_out_valid (bus.out_valid),
    .o_drop      (w_drop)
  );

  assign bus.bit_count = r_bit_count;
  assign bus.overflow  = r_overflow;

endmodule : sipo

`default_nettype wire

// File: doc/sipo.md
# sipo

Serial-in parallel-out deserializer for the decompressor datapath; the receive-side counterpart of the 4-bit PISO serializer. Samples one bit per `shift_en` cycle MSB-first, counts bits to word boundaries, and presents each completed WIDTH-bit word on a one-entry valid/ready output slot. Overrun, meaning a word completing while the slot is still held, is reported by a sticky flag.

## Interface
Parameters:
- `WIDTH`, default 4: word width in bits, must be at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous word realign: drops the partial word and clears `overflow`.
- `shift_en`  in  1  `serial_in` is valid this cycle and is sampled.
- `serial_in`  in  1  serial data, MSB of each word first.
- `out_data`  out  WIDTH  completed word, stable while `out_valid` is high.
- `out_valid`  out  1  the slot holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `out_data` when high together with `out_valid`.
- `bit_count`  out  max(1,$clog2(WIDTH))  number of bits collected in the current partial word.
- `overflow`  out  1  sticky: a completed word was dropped.

## Operation
- Internal state:
  - `sr`: WIDTH-1 bits of partial word.
  - `bit_count`: counter that wraps to 0 after WIDTH-1.
  - Slot FSM, EMPTY/FULL: `out_valid` = (state == FULL).
- Shift (`shift_en`=1, `clear`=0):
  - `sr` <= {`sr`[WIDTH-3:0], `serial_in`}.
  - `bit_count` increments.
- Completion: a shift with `bit_count`==WIDTH-1 completes a word.
  - Word = {`sr`, `serial_in`}, so the first bit received lands in `out_data`[WIDTH-1].
  - `bit_count` <= 0.
- Slot transitions:
  - EMPTY + completion → FULL, load `out_data`.
  - FULL + `out_ready` + completion → FULL. Load the new word; no bubble and no overflow.
  - FULL + `out_ready`, no completion → EMPTY. `out_data` keeps its last value.
  - FULL, no `out_ready`, + completion → FULL. The new word is discarded, `out_data` is unchanged, and `overflow` <= 1.
  - Otherwise the state holds.
- `clear` has priority over `shift_en`:
  - `bit_count` <= 0, `sr` <= 0, `overflow` <= 0.
  - The slot and its handshake are unaffected, so a pending word can still be consumed.
  - The `serial_in` bit in a `clear` cycle is not sampled.
- `shift_en`=0: `sr` and `bit_count` hold. The slot still drains on `out_ready`.
- `out_ready` while EMPTY has no effect.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `bit_count`=0, `overflow`=0, internal `sr`=0, slot=EMPTY.
- Reset may assert at any point, including mid-word or with the slot FULL. All state returns to reset values immediately; no word is emitted.
- Latency: `out_valid` rises on the clock edge that samples the WIDTH-th bit, so the word is visible the cycle after that bit's `shift_en` cycle.
- Throughput: with `out_ready` held high, back-to-back words at one bit per cycle never overflow.
- `out_data` and `out_valid` are registered outputs. There is no combinational path from `serial_in`, `shift_en` or `out_ready` to any output.
- `overflow` rises the cycle after the dropped completion and stays high until `clear` or reset.
- Combined with the PISO serializer, the loop is load at cycle t, shift at t+1..t+WIDTH, `out_valid` at t+WIDTH+1 with equal data, provided `shift_en` is wired so the receiver samples the same WIDTH cycles.

## Structure
- Shared package `sipo_pkg`:
  - Slot-state encoding (EMPTY=1'b0, FULL=1'b1).
  - Counter-width constant/function CNT_W = max(1,$clog2(WIDTH)).
  - The same package is used by the verification bench.
- One sub-module is natural: `sipo_out_slot`, a one-entry valid/ready holding register.
  - Inputs: `load`, `load_data`, `out_ready`.
  - Outputs: `out_data`, `out_valid`, `drop` (load while full and not draining).
- The top level holds the shift register, the bit counter and the `overflow` flag.

## Test plan
- WIDTH=4, `out_ready`=1, shift bits 1,0,1,1 on consecutive cycles → next cycle `out_valid`=1, `out_data`=4'b1011, `bit_count`=0; `out_valid` drops the following cycle.
- Loopback with PISO loading 4'hA, then 4'h5, with 4 shifts each and `shift_en` driving both → receiver emits 4'hA then 4'h5, `overflow`=0.
- `out_ready`=0: send 4'hC then 4'h3 → `out_data` stays 4'hC, `overflow`=1 after the 8th bit; assert `out_ready` → 4'hC is consumed, `out_valid`=0.
- Slot FULL with 4'h9; the completion of 4'h6 coincides with `out_ready`=1 → `out_valid` stays 1, `out_data`=4'h6, `overflow`=0.
- Shift 1,1, then `clear`, then shift 0,1,0,1 → `out_data`=4'h5 (not a mix with 1,1); `bit_count` was 0 after `clear`.
- Assert `rst_n`=0 with `bit_count`=3 and slot FULL → all outputs are 0 immediately; after release, a fresh 4-bit word is received correctly.
